rc_settle_monitor: RTL and testbench
====================================

Name: rc_settle_monitor

Overview:
- Downstream observer of the RC model stage. Watches the model's drive input (v_in) and its response (v_out).
- A change on v_in is a step. On each step it measures the cycles until v_out settles within a tolerance band around the new v_in.
- Also reports overshoot and peak error, and flags a timeout.
- Drop-in bench and regression checker replacing manual waits and asserts around the RC model.

Parameters:
- WIDTH, 8, bit width of v_in/v_out/max_err.
- TOL, 2, settle band half-width in LSBs (in band when |v_out - target| <= TOL).
- HOLD, 4, consecutive in-band cycles required to declare settled (>=1).
- TIMEOUT, 1000, cycle count at which an unsettled step is abandoned (< 2^CNT_W - 1).
- CNT_W, 16, width of the cycle counter and settle_cycles.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- v_in  input  WIDTH  RC model input (step target).
- v_out  input  WIDTH  RC model output (response).
- busy  output  1  high while a step is being tracked.
- done  output  1  one-cycle pulse when a step resolves (settled or timed out).
- settled  output  1  level; last step settled.
- timed_out  output  1  level; last step timed out.
- overshoot  output  1  level; v_out crossed beyond target by more than TOL during the last step.
- settle_cycles  output  CNT_W  cycle index of the start of the final in-band run; all-ones on timeout.
- max_err  output  WIDTH  peak |v_out - target| observed during the last step.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - All outputs go to 0 and internal counters go to 0.
  - v_in_q loads v_in, so no step is seen on the first cycle after reset.
  - rst asserted mid-track aborts the track with no done pulse.
- Step detect: at any non-reset edge where v_in != v_in_q:
  - target <= v_in, start <= v_out, count <= 0, hold <= 0, max_err <= 0.
  - overshoot, settled and timed_out clear.
  - State goes to TRACK and busy goes to 1.
  - This applies from any state. A step wins over a same-edge settle or timeout, and no done pulse is issued.
- v_in_q <= v_in every edge.
- States: IDLE, TRACK, SETTLED, TIMEOUT. SETTLED and TIMEOUT hold their results until the next step or reset. busy = (state == TRACK).
- TRACK, each edge without a step:
  - count_n = count + 1, saturating at all-ones.
  - err = |v_out - target|, computed in WIDTH+1 bits, result WIDTH bits.
  - max_err <= max(max_err, err).
  - Overshoot:
    - If target > start and v_out > target + TOL, overshoot <= 1.
    - If target < start and v_out + TOL < target, overshoot <= 1.
    - If target == start, overshoot never sets.
  - If err <= TOL:
    - If hold == 0, entry <= count_n.
    - hold <= hold + 1.
    - If hold + 1 == HOLD: state goes to SETTLED, settled <= 1, settle_cycles <= entry (count_n when HOLD == 1), done <= 1.
  - Else hold <= 0.
  - If not settling this edge and count_n == TIMEOUT: state goes to TIMEOUT, timed_out <= 1, settle_cycles <= all-ones, done <= 1.
- done is high for exactly one cycle, the cycle after the resolving edge. done is low otherwise.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 1 cycle with v_in=0 and v_out=0, then hold for 20 cycles -> all outputs 0, busy=0, no done.
- Clean step: v_in 0->64 at edge E; v_out=0 for edges E+1..E+10, then 63 -> done at edge E+14, settled=1, settle_cycles=11, overshoot=0, max_err=64.
- Overshoot: v_in 0->64; v_out=0 for 5 edges, 70 for 3, then 64 -> settled=1, overshoot=1, settle_cycles=9, max_err=64.
- Ring-in: v_in 0->64; v_out=63 for 2 edges, 60 for 1, then 64 -> hold restarts, settle_cycles=4, done at edge E+7.
- Timeout with TIMEOUT=200: v_in 0->32 with v_out stuck at 0 -> done at count 200, timed_out=1, settle_cycles=16'hFFFF, max_err=32.
- Restep and reset:
  - v_in 64->32 during TRACK at count 5 -> count restarts at 0 with no done.
  - rst mid-track -> IDLE, all outputs 0.
  - v_in change on the same edge as a HOLD completion -> new track, settled=0, no done pulse.

Source files
------------

// File: rtl/rc_settle_monitor.sv
// Observer for an RC model stage: on every step of v_in, measures how long v_out takes to
// settle inside a +/-TOL band around the new target, and tracks overshoot, peak error and timeout.
module rc_settle_monitor #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TOL     = 2,
  parameter int unsigned HOLD    = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v_in,
  input  logic [WIDTH-1:0] v_out,
  output logic             busy,
  output logic             done,
  output logic             settled,
  output logic             timed_out,
  output logic             overshoot,
  output logic [CNT_W-1:0] settle_cycles,
  output logic [WIDTH-1:0] max_err
);

  // Two spare bits so target + TOL and v_out + TOL never wrap.
  localparam int unsigned      ExtW       = WIDTH + 2;
  localparam logic [ExtW-1:0]  TolExt     = ExtW'(TOL);
  localparam logic [CNT_W-1:0] HoldCnt    = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StTrack, StSettled, StTimeout} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] v_in_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] start_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] entry_q;

  logic             step;
  logic             in_band;
  logic             over_hi;
  logic             over_lo;
  logic             settle_now;
  logic             timeout_now;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] hold_n;
  logic [CNT_W-1:0] entry_n;
  logic [WIDTH-1:0] err;
  logic [ExtW-1:0]  out_ext;
  logic [ExtW-1:0]  tgt_ext;

  always_comb begin
    step        = (v_in != v_in_q);
    count_n     = (&count_q) ? count_q : count_q + CNT_W'(1);
    err         = (v_out >= target_q) ? v_out - target_q : target_q - v_out;
    in_band     = (ExtW'(err) <= TolExt);
    out_ext     = ExtW'(v_out);
    tgt_ext     = ExtW'(target_q);
    over_hi     = (target_q > start_q) && (out_ext > tgt_ext + TolExt);
    over_lo     = (target_q < start_q) && (out_ext + TolExt < tgt_ext);
    hold_n      = hold_q + CNT_W'(1);
    // The in-band run starts at this edge when no run was in progress.
    entry_n     = (hold_q == '0) ? count_n : entry_q;
    settle_now  = in_band && (hold_n == HoldCnt);
    timeout_now = !settle_now && (count_n == TimeoutCnt);
  end

  always_ff @(posedge clk) begin
    v_in_q <= v_in;
    done   <= 1'b0;
    if (rst) begin
      state_q       <= StIdle;
      target_q      <= '0;
      start_q       <= '0;
      count_q       <= '0;
      hold_q        <= '0;
      entry_q       <= '0;
      settled       <= 1'b0;
      timed_out     <= 1'b0;
      overshoot     <= 1'b0;
      settle_cycles <= '0;
      max_err       <= '0;
    end else if (step) begin
      // A new step overrides any resolution that would have happened on this edge.
      state_q   <= StTrack;
      target_q  <= v_in;
      start_q   <= v_out;
      count_q   <= '0;
      hold_q    <= '0;
      max_err   <= '0;
      overshoot <= 1'b0;
      settled   <= 1'b0;
      timed_out <= 1'b0;
    end else if (state_q == StTrack) begin
      count_q <= count_n;
      if (err > max_err) max_err <= err;
      if (over_hi || over_lo) overshoot <= 1'b1;
      if (in_band) begin
        hold_q  <= hold_n;
        entry_q <= entry_n;
      end else begin
        hold_q <= '0;
      end
      if (settle_now) begin
        state_q       <= StSettled;
        settled       <= 1'b1;
        settle_cycles <= entry_n;
        done          <= 1'b1;
      end else if (timeout_now) begin
        state_q       <= StTimeout;
        timed_out     <= 1'b1;
        settle_cycles <= '1;
        done          <= 1'b1;
      end
    end
  end

  assign busy = (state_q == StTrack);

endmodule

// File: tb/tb_rc_settle_monitor.sv
// Bench for rc_settle_monitor: directed step scenarios from a table, hand-written corner
// sequences, and random stimulus compared every cycle against a sample-history model.
module tb_rc_settle_monitor;

  localparam int WIDTH   = 8;
  localparam int TOL     = 2;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 200;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] v_in;
  logic [WIDTH-1:0] v_out;
  logic             busy;
  logic             done;
  logic             settled;
  logic             timed_out;
  logic             overshoot;
  logic [CNT_W-1:0] settle_cycles;
  logic [WIDTH-1:0] max_err;

  int n_checks = 0;
  int n_fail   = 0;

  rc_settle_monitor #(
    .WIDTH  (WIDTH),
    .TOL    (TOL),
    .HOLD   (HOLD),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .v_in         (v_in),
    .v_out        (v_out),
    .busy         (busy),
    .done         (done),
    .settled      (settled),
    .timed_out    (timed_out),
    .overshoot    (overshoot),
    .settle_cycles(settle_cycles),
    .max_err      (max_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: keeps the list of v_out samples seen since the step.
  bit m_track, m_done, m_settled, m_to, m_ovs;
  int m_prev, m_target, m_start, m_max, m_sc;
  int samples[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_edge(input bit r, input int vi, input int vo);
    int n;
    bit ok;
    m_done = 1'b0;
    if (r) begin
      m_track = 0; m_settled = 0; m_to = 0; m_ovs = 0; m_max = 0; m_sc = 0;
      samples.delete();
    end else if (vi != m_prev) begin
      m_track = 1; m_target = vi; m_start = vo; m_max = 0;
      m_ovs = 0; m_settled = 0; m_to = 0;
      samples.delete();
    end else if (m_track) begin
      samples.push_back(vo);
      if (absdiff(vo, m_target) > m_max) m_max = absdiff(vo, m_target);
      if (m_target > m_start && vo > m_target + TOL) m_ovs = 1;
      if (m_target < m_start && vo + TOL < m_target) m_ovs = 1;
      n  = samples.size();
      ok = (n >= HOLD);
      for (int i = n - HOLD; ok && i < n; i++)
        if (absdiff(samples[i], m_target) > TOL) ok = 0;
      if (ok) begin
        m_track = 0; m_settled = 1; m_done = 1; m_sc = n - HOLD + 1;
      end else if (n == TIMEOUT) begin
        m_track = 0; m_to = 1; m_done = 1; m_sc = (1 << CNT_W) - 1;
      end
    end
    m_prev = vi;
  endtask

  task automatic compare_all();
    check("busy", int'(busy), int'(m_track));
    check("done", int'(done), int'(m_done));
    check("settled", int'(settled), int'(m_settled));
    check("timed_out", int'(timed_out), int'(m_to));
    check("overshoot", int'(overshoot), int'(m_ovs));
    check("max_err", int'(max_err), m_max);
    check("settle_cycles", int'(settle_cycles), m_sc);
  endtask

  task automatic tick(input bit r, input int vi, input int vo);
    rst   = r;
    v_in  = WIDTH'(vi);
    v_out = WIDTH'(vo);
    @(posedge clk);
    model_edge(r, vi, vo);
    #1;
    compare_all();
  endtask

  typedef struct {
    string name;
    int init_vin; int target; int start;
    int v0; int n0; int v1; int n1; int v2;
    int done_at; bit exp_settled; bit exp_to; bit exp_ovs; int exp_sc; int exp_max;
  } scen_t;

  scen_t scen[6];

  initial begin
    int done_at;
    int vo;
    int tgt, cur, noise;
    bit stuck, r;

    rst = 1'b1; v_in = '0; v_out = '0;
    m_prev = 0;

    scen[0] = '{"clean",     0, 64,   0,   0, 10, 63, 0, 63,  14, 1, 0, 0, 11,     64};
    scen[1] = '{"overshoot", 0, 64,   0,   0,  5, 70, 3, 64,  12, 1, 0, 1,  9,     64};
    scen[2] = '{"ring_in",   0, 64,   0,  63,  2, 60, 1, 64,   7, 1, 0, 0,  4,      4};
    scen[3] = '{"timeout",   0, 32,   0,   0,  0,  0, 0,  0, 200, 0, 1, 0, 'hFFFF, 32};
    scen[4] = '{"down",    100, 40, 100, 100,  1, 36, 2, 40,   7, 1, 0, 1,  4,     60};
    scen[5] = '{"flat",     50, 52,  52,  60,  1, 45, 1, 52,   6, 1, 0, 0,  3,      8};

    // Reset and quiet period.
    tick(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0);
      check("reset_quiet", int'({busy, done, settled, timed_out, overshoot}), 0);
      check("reset_counts", int'(settle_cycles) + int'(max_err), 0);
    end

    // Table-driven step scenarios.
    foreach (scen[k]) begin
      tick(1, scen[k].init_vin, scen[k].init_vin);
      tick(0, scen[k].init_vin, scen[k].init_vin);
      tick(0, scen[k].init_vin, scen[k].init_vin);
      tick(0, scen[k].target, scen[k].start);
      check({scen[k].name, "_busy"}, int'(busy), 1);
      done_at = -1;
      for (int off = 1; off <= 300 && done_at < 0; off++) begin
        if (off <= scen[k].n0) vo = scen[k].v0;
        else if (off <= scen[k].n0 + scen[k].n1) vo = scen[k].v1;
        else vo = scen[k].v2;
        tick(0, scen[k].target, vo);
        if (done) done_at = off;
      end
      check({scen[k].name, "_done_edge"}, done_at, scen[k].done_at);
      check({scen[k].name, "_settled"}, int'(settled), int'(scen[k].exp_settled));
      check({scen[k].name, "_timed_out"}, int'(timed_out), int'(scen[k].exp_to));
      check({scen[k].name, "_overshoot"}, int'(overshoot), int'(scen[k].exp_ovs));
      check({scen[k].name, "_settle_cycles"}, int'(settle_cycles), scen[k].exp_sc);
      check({scen[k].name, "_max_err"}, int'(max_err), scen[k].exp_max);
      tick(0, scen[k].target, scen[k].v2);
      check({scen[k].name, "_done_pulse"}, int'(done), 0);
      check({scen[k].name, "_hold_result"}, int'(settled | timed_out), 1);
    end

    // Restep at count 5: counting restarts from the new step.
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 64, 0);
    for (int i = 0; i < 5; i++) tick(0, 64, 0);
    tick(0, 32, 0);
    check("restep_busy", int'(busy), 1);
    check("restep_no_done", int'(done), 0);
    done_at = -1;
    for (int off = 1; off <= 20 && done_at < 0; off++) begin
      tick(0, 32, (off <= 3) ? 0 : 32);
      if (done) done_at = off;
    end
    check("restep_done_edge", done_at, 7);
    check("restep_settle_cycles", int'(settle_cycles), 4);
    check("restep_max_err", int'(max_err), 32);

    // Reset in the middle of a track.
    tick(0, 90, 0);
    for (int i = 0; i < 3; i++) tick(0, 90, 10);
    tick(1, 90, 10);
    check("midrst_quiet", int'({busy, done, settled, timed_out, overshoot}), 0);
    check("midrst_counts", int'(settle_cycles) + int'(max_err), 0);
    tick(0, 90, 10);
    check("midrst_no_step", int'({busy, done}), 0);

    // Step on the same edge that would complete the hold run.
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 64, 0);
    for (int i = 0; i < 3; i++) tick(0, 64, 64);
    tick(0, 20, 64);
    check("collide_busy", int'(busy), 1);
    check("collide_settled", int'(settled), 0);
    check("collide_done", int'(done), 0);
    tick(0, 20, 64);
    check("collide_done_next", int'(done), 0);

    // Random stimulus against the model.
    tgt = 0; cur = 0; stuck = 0;
    tick(1, 0, 0);
    for (int c = 0; c < 6000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 119) == 0) begin
        tgt   = $urandom_range(0, 255);
        stuck = ($urandom_range(0, 5) == 0);
      end
      if (!stuck) begin
        noise = $urandom_range(0, 6);
        cur   = cur + (tgt - cur) / 2 + noise - 3;
        if ($urandom_range(0, 15) == 0) cur = $urandom_range(0, 255);
        if (cur < 0) cur = 0;
        if (cur > 255) cur = 255;
      end
      tick(r, tgt, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
